// File: rtl/instruction_fetcher_pkg.sv
// -----------------------------------------------------------------------------
// instruction_fetcher_pkg
//
// Shared types and constants for the fetch front end:
//   addr_t / inst_t   32-bit address and instruction words
//   ZERO_ADDR / ZERO_INST / PC_STEP
//   fetch_state_e     fetch FSM state encoding
//   fetch_entry_t     {valid, inst, pc}; used both for the instruction-queue
//                     output register and for the one-entry pending buffer
//   next_pc()         sequential PC advance (32-bit modulo wrap)
// -----------------------------------------------------------------------------
package instruction_fetcher_pkg;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [INST_W-1:0] inst_t;

  localparam addr_t ZERO_ADDR = '0;
  localparam inst_t ZERO_INST = '0;
  localparam addr_t PC_STEP   = 32'd4;

  // IDLE: lookups allowed. WAIT_MEM: exactly one miss outstanding.
  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic  valid;
    inst_t inst;
    addr_t pc;
  } fetch_entry_t;

  localparam fetch_entry_t EMPTY_ENTRY = '{valid: 1'b0, inst: ZERO_INST, pc: ZERO_ADDR};

  // Plain 32-bit addition: 32'hFFFF_FFFC + 4 wraps to 0 by construction.
  function automatic addr_t next_pc(input addr_t pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/instruction_fetcher_icache_array.sv
// -----------------------------------------------------------------------------
// icache_array
//
// Direct-mapped instruction cache storage, one 32-bit word per line.
//   clk             clock
//   rst             synchronous active-high reset; clears every valid bit
//   lookup_index_i  line index of the address being looked up
//   lookup_tag_i    tag of the address being looked up
//   hit_o           combinational: line valid and tag matches
//   data_o          combinational: word stored in the indexed line
//   we_i            write enable (fill from memory)
//   write_index_i   line index to fill
//   write_tag_i     tag to store with the fill
//   wdata_i         word to store
// The address split (index/tag) is done by the caller so this block only
// ever sees the bits it actually uses.
// -----------------------------------------------------------------------------
module icache_array
  import instruction_fetcher_pkg::*;
#(
  parameter  int INDEX_BITS = 8,
  localparam int TAG_BITS   = ADDR_W - INDEX_BITS - 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] lookup_index_i,
  input  logic [TAG_BITS-1:0]   lookup_tag_i,
  output logic                  hit_o,
  output logic [INST_W-1:0]     data_o,
  input  logic                  we_i,
  input  logic [INDEX_BITS-1:0] write_index_i,
  input  logic [TAG_BITS-1:0]   write_tag_i,
  input  logic [INST_W-1:0]     wdata_i
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_q  [LINES];
  inst_t               data_q [LINES];

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[write_index_i] <= 1'b1;
    end
  end

  // NOTE: tag/data storage has no reset; every lookup is qualified by the
  // valid bit, so stale contents are never observed and the arrays stay
  // mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[write_index_i]  <= write_tag_i;
      data_q[write_index_i] <= wdata_i;
    end
  end

  assign hit_o  = valid_q[lookup_index_i] && (tag_q[lookup_index_i] == lookup_tag_i);
  assign data_o = data_q[lookup_index_i];

endmodule

// File: rtl/instruction_fetcher.sv
// -----------------------------------------------------------------------------
// instruction_fetcher
//
// Fetch front end. Holds the architectural fetch PC, looks it up in a
// direct-mapped I-cache, delivers one instruction per cycle on hits and
// issues single-word queries to memory_controller on misses. A ROB rollback
// (stop_signal) redirects the PC and cancels any in-flight miss.
//
// Ports:
//   clk                  clock, all state on posedge
//   rst                  synchronous active-high reset
//   rdy                  global enable; when low every register holds
//   pc_to_mc             miss address to memory_controller (registered)
//   start_query_signal   one-rdy-cycle miss request (registered)
//   finish_query_signal  memory_controller word is ready
//   inst_from_mc         returned word
//   stop_signal          rollback from ROB
//   target_pc_from_rob   redirect PC, valid with stop_signal
//   iq_full_signal       instruction queue cannot accept this cycle
//   inst_valid_to_iq     instruction presented (one-cycle pulse, registered)
//   inst_to_iq           instruction word (registered)
//   pc_to_iq             PC of inst_to_iq (registered)
// -----------------------------------------------------------------------------
module instruction_fetcher
  import instruction_fetcher_pkg::*;
#(
  parameter int    ICACHE_INDEX_BITS = 8,
  parameter addr_t RESET_PC          = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  output logic [ADDR_W-1:0] pc_to_mc,
  output logic              start_query_signal,
  input  logic              finish_query_signal,
  input  logic [INST_W-1:0] inst_from_mc,
  input  logic              stop_signal,
  input  logic [ADDR_W-1:0] target_pc_from_rob,
  input  logic              iq_full_signal,
  output logic              inst_valid_to_iq,
  output logic [INST_W-1:0] inst_to_iq,
  output logic [ADDR_W-1:0] pc_to_iq
);

  // Address split: index = pc[INDEX_MSB:INDEX_LSB], tag = pc[31:TAG_LSB].
  localparam int INDEX_LSB = 2;
  localparam int INDEX_MSB = ICACHE_INDEX_BITS + 1;
  localparam int TAG_LSB   = ICACHE_INDEX_BITS + 2;
  localparam int TAG_BITS  = ADDR_W - ICACHE_INDEX_BITS - 2;

  fetch_state_e state_q, state_d;
  addr_t        pc_q, pc_d;
  addr_t        mc_pc_q, mc_pc_d;      // address of the outstanding miss
  logic         start_q, start_d;
  fetch_entry_t iq_q, iq_d;            // output register toward the IQ
  fetch_entry_t pend_q, pend_d;        // fill that arrived while the IQ was full

  logic                         cache_hit;
  inst_t                        cache_data;
  logic                         cache_we;
  logic [ICACHE_INDEX_BITS-1:0] lookup_index, fill_index;
  logic [TAG_BITS-1:0]          lookup_tag, fill_tag;

  assign lookup_index = pc_q[INDEX_MSB:INDEX_LSB];
  assign lookup_tag   = pc_q[ADDR_W-1:TAG_LSB];
  // The fill always targets the miss address, which stays correct even when
  // a rollback has already moved pc_q in the same cycle.
  assign fill_index   = mc_pc_q[INDEX_MSB:INDEX_LSB];
  assign fill_tag     = mc_pc_q[ADDR_W-1:TAG_LSB];

  icache_array #(
    .INDEX_BITS (ICACHE_INDEX_BITS)
  ) u_icache (
    .clk            (clk),
    .rst            (rst),
    .lookup_index_i (lookup_index),
    .lookup_tag_i   (lookup_tag),
    .hit_o          (cache_hit),
    .data_o         (cache_data),
    .we_i           (cache_we),
    .write_index_i  (fill_index),
    .write_tag_i    (fill_tag),
    .wdata_i        (inst_from_mc)
  );

  // Next-state / output logic. Priority within an enabled cycle:
  // rollback > pending-buffer drain > lookup / miss completion.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    state_d  = state_q;
    pc_d     = pc_q;
    mc_pc_d  = mc_pc_q;
    start_d  = start_q;
    iq_d     = iq_q;
    pend_d   = pend_q;
    cache_we = 1'b0;

    if (rdy) begin
      // Both pulses last exactly one enabled cycle; during rdy-low cycles
      // they hold, so memory_controller sees the request exactly once.
      start_d    = 1'b0;
      iq_d.valid = 1'b0;

      // A returning word is always written, even if a rollback discards it.
      if (state_q == WAIT_MEM && finish_query_signal) begin
        cache_we = 1'b1;
      end

      if (stop_signal) begin
        pc_d         = target_pc_from_rob;
        state_d      = IDLE;
        pend_d.valid = 1'b0;
      end else if (pend_q.valid) begin
        // Draining the pending word takes the cycle; no lookup happens.
        if (!iq_full_signal) begin
          iq_d         = pend_q;
          pend_d.valid = 1'b0;
        end
      end else begin
        unique case (state_q)
          IDLE: begin
            if (!iq_full_signal) begin
              if (cache_hit) begin
                iq_d = '{valid: 1'b1, inst: cache_data, pc: pc_q};
                pc_d = next_pc(pc_q);
              end else begin
                mc_pc_d = pc_q;
                start_d = 1'b1;
                state_d = WAIT_MEM;
              end
            end
          end
          WAIT_MEM: begin
            if (finish_query_signal) begin
              if (!iq_full_signal) begin
                iq_d = '{valid: 1'b1, inst: inst_from_mc, pc: pc_q};
              end else begin
                pend_d = '{valid: 1'b1, inst: inst_from_mc, pc: pc_q};
              end
              pc_d    = next_pc(pc_q);
              state_d = IDLE;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      mc_pc_q <= ZERO_ADDR;
      start_q <= 1'b0;
      iq_q    <= EMPTY_ENTRY;
      pend_q  <= EMPTY_ENTRY;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mc_pc_q <= mc_pc_d;
      start_q <= start_d;
      iq_q    <= iq_d;
      pend_q  <= pend_d;
    end
  end

  assign pc_to_mc           = mc_pc_q;
  assign start_query_signal = start_q;
  assign inst_valid_to_iq   = iq_q.valid;
  assign inst_to_iq         = iq_q.inst;
  assign pc_to_iq           = iq_q.pc;

endmodule
